// File: rtl/ls161_pkg.sv
// Shared definitions for the LS161 sequencer and the bench around it.
package ls161_pkg;

  // Default width of the repeat count and the completed-periods tally.
  localparam int CNT_W_DEF = 8;

  // The downstream counter is a fixed 4-bit part.
  localparam int PRE_W = 4;

  // Counter value at which RCO is raised.
  localparam logic [PRE_W-1:0] CNT_TERM = 4'hF;

  // IDLE: waiting for START; LOAD: one cycle presenting LOAD_n low;
  // COUNT: counter enabled, reloading on every terminal count.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

endpackage

// File: rtl/ls161_seq_ctrl_if.sv
// Control/status bundle between the sequencer and its user/counter.
interface ls161_seq_ctrl_if
  import ls161_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             START;
  logic             STOP;
  logic             HOLD;
  logic [PRE_W-1:0] PRESET;
  logic [CNT_W-1:0] REPEAT;
  logic             RCO;

  logic [PRE_W-1:0] D;
  logic             LOAD_n;
  logic             ENP;
  logic             ENT;
  logic             BUSY;
  logic             TICK;
  logic             DONE;
  logic [CNT_W-1:0] PERIODS;

  // Side that requests runs and hosts the counter.
  modport master (
    output START, STOP, HOLD, PRESET, REPEAT, RCO,
    input  D, LOAD_n, ENP, ENT, BUSY, TICK, DONE, PERIODS
  );

  // The sequencer itself.
  modport slave (
    input  START, STOP, HOLD, PRESET, REPEAT, RCO,
    output D, LOAD_n, ENP, ENT, BUSY, TICK, DONE, PERIODS
  );

endinterface

// File: rtl/ls161_seq_ctrl.sv
// Sequencer that drives an LS161-style counter as a programmable divider:
// load PRESET, count to terminal, reload on RCO, tally periods, flag DONE.
module ls161_seq_ctrl
  import ls161_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                CLK,
  input  logic                CLR_n,
  ls161_seq_ctrl_if.slave     bus
);

  state_e           r_state;
  state_e           w_state_next;
  logic [PRE_W-1:0] r_d;
  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] r_periods;
  logic             r_tick;
  logic             r_done;

  logic             w_term;
  logic [CNT_W-1:0] w_periods_inc;
  logic             w_last;

  // A terminal only counts while the counter is actually allowed to advance;
  // with HOLD high the counter sits at 15 and RCO is ignored.
  assign w_term        = (r_state == ST_COUNT) && bus.RCO && !bus.HOLD;
  assign w_periods_inc = r_periods + CNT_W'(1);
  assign w_last        = (r_rep != '0) && (w_periods_inc == r_rep);

  // State register.
  always_ff @(posedge CLK) begin
    if (!CLR_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decision; STOP wins over completion, START only from IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.START) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = bus.STOP ? ST_IDLE : ST_COUNT;
      ST_COUNT: begin
        if (bus.STOP || (w_term && w_last)) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Latched run parameters, the period tally and the one-cycle pulses.
  always_ff @(posedge CLK) begin
    if (!CLR_n) begin
      r_d       <= '0;
      r_rep     <= '0;
      r_periods <= '0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tick <= w_term;
      r_done <= w_term && w_last && !bus.STOP;
      if (r_state == ST_IDLE && bus.START) begin
        r_d       <= bus.PRESET;
        r_rep     <= bus.REPEAT;
        r_periods <= '0;
      end else if (w_term) begin
        r_periods <= w_periods_inc;
      end
    end
  end

  // Counter controls; LOAD_n follows RCO combinationally in COUNT so the
  // counter reloads D instead of wrapping to 0.
  always_comb begin
    bus.D       = r_d;
    bus.LOAD_n  = 1'b1;
    bus.ENP     = 1'b0;
    bus.ENT     = 1'b0;
    bus.BUSY    = 1'b0;
    bus.TICK    = r_tick;
    bus.DONE    = r_done;
    bus.PERIODS = r_periods;
    case (r_state)
      ST_LOAD: begin
        bus.LOAD_n = 1'b0;
        bus.BUSY   = 1'b1;
      end
      ST_COUNT: begin
        bus.LOAD_n = !w_term;
        bus.ENP    = !bus.HOLD;
        bus.ENT    = 1'b1;
        bus.BUSY   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ls161_seq_ctrl.sv
// Bench: sequencer driving a behavioural LS161 counter, checked each cycle
// against a reference model of the divider behaviour.
module tb_ls161_seq_ctrl;
  import ls161_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  ls161_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  ls161_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .CLR_n (clr_n),
    .bus   (bus)
  );

  // Downstream LS161-style counter: async clear, sync load, count on ENP&ENT.
  logic [3:0] q;
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n)                  q <= 4'd0;
    else if (!bus.LOAD_n)        q <= bus.D;
    else if (bus.ENP && bus.ENT) q <= q + 4'd1;
  end
  assign bus.RCO = (q == CNT_TERM) && bus.ENT;

  // Reference model state.
  bit m_active, m_loading, m_tick, m_done;
  int m_q, m_d, m_rep, m_periods;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int c0;
  int done_cycle;
  int tick_cycles[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic drive(input bit st, input bit sp, input bit hd,
                       input logic [3:0] pre, input logic [7:0] rep);
    bus.START  = st;
    bus.STOP   = sp;
    bus.HOLD   = hd;
    bus.PRESET = pre;
    bus.REPEAT = rep;
  endtask

  // One clock cycle: compare outputs mid-low-phase, advance model, wait.
  task automatic step();
    bit ent, enp, term, ld;
    int nq;
    #1;
    if (!clr_n) m_q = 0;
    ent  = m_active && !m_loading;
    enp  = ent && !bus.HOLD;
    term = enp && (m_q == 15);
    ld   = m_loading || term;
    check("D",       bus.D,       m_d);
    check("LOAD_n",  bus.LOAD_n,  !ld);
    check("ENP",     bus.ENP,     enp);
    check("ENT",     bus.ENT,     ent);
    check("BUSY",    bus.BUSY,    m_active);
    check("TICK",    bus.TICK,    m_tick);
    check("DONE",    bus.DONE,    m_done);
    check("PERIODS", bus.PERIODS, m_periods);
    check("Q",       q,           m_q);
    if (bus.TICK === 1'b1) tick_cycles.push_back(cyc);
    if (bus.DONE === 1'b1) done_cycle = cyc;
    if (!clr_n) begin
      m_active = 0; m_loading = 0; m_tick = 0; m_done = 0;
      m_d = 0; m_periods = 0; m_q = 0;
    end else begin
      nq = ld ? m_d : (enp ? (m_q + 1) % 16 : m_q);
      m_tick = term;
      m_done = 0;
      if (!m_active) begin
        if (bus.START) begin
          m_active = 1; m_loading = 1;
          m_d = int'(bus.PRESET); m_rep = int'(bus.REPEAT); m_periods = 0;
        end
      end else if (m_loading) begin
        m_loading = 0;
        if (bus.STOP) m_active = 0;
      end else begin
        if (term) begin
          m_periods = (m_periods + 1) % 256;
          if (m_rep != 0 && m_periods == m_rep && !bus.STOP) begin
            m_active = 0; m_done = 1;
          end
        end
        if (bus.STOP) m_active = 0;
      end
      m_q = nq;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic begin_scenario();
    tick_cycles.delete();
    done_cycle = -1;
    c0 = cyc;
  endtask

  initial begin
    clr_n = 1'b0;
    drive(0, 0, 0, 4'd0, 8'd0);
    m_active = 0; m_loading = 0; m_tick = 0; m_done = 0;
    m_q = 0; m_d = 0; m_rep = 0; m_periods = 0;
    repeat (2) @(negedge clk);
    run(1);                       // reset values under CLR_n low
    clr_n = 1'b1;
    run(2);

    // Reset in the middle of a count.
    drive(1, 0, 0, 4'd8, 8'd0); step();
    drive(0, 0, 0, 4'd8, 8'd0); run(5);
    clr_n = 1'b0; run(2);
    clr_n = 1'b1; run(2);

    // PRESET=12, REPEAT=3: ticks at +6/+10/+14, DONE at +14.
    begin_scenario();
    drive(1, 0, 0, 4'd12, 8'd3); step();
    drive(0, 0, 0, 4'd12, 8'd3); run(17);
    check("p2_tick_count", tick_cycles.size(), 3);
    if (tick_cycles.size() == 3) begin
      check("p2_tick0", tick_cycles[0] - c0, 6);
      check("p2_tick1", tick_cycles[1] - c0, 10);
      check("p2_tick2", tick_cycles[2] - c0, 14);
    end
    check("p2_done", done_cycle - c0, 14);

    // HOLD for three cycles while Q=15 stretches the first period.
    begin_scenario();
    drive(1, 0, 0, 4'd12, 8'd2); step();
    drive(0, 0, 0, 4'd12, 8'd2); run(4);
    drive(0, 0, 1, 4'd12, 8'd2); run(3);
    drive(0, 0, 0, 4'd12, 8'd2); run(8);
    check("p3_first_tick", (tick_cycles.size() > 0) ? tick_cycles[0] - c0 : -1, 9);
    check("p3_done", done_cycle - c0, 13);

    // PRESET=15: terminal every COUNT cycle.
    begin_scenario();
    drive(1, 0, 0, 4'd15, 8'd5); step();
    drive(0, 0, 0, 4'd15, 8'd5); run(9);
    check("p4_tick_count", tick_cycles.size(), 5);
    check("p4_done", done_cycle - c0, 7);

    // STOP coinciding with a terminal (PRESET=14, REPEAT=0).
    begin_scenario();
    drive(1, 0, 0, 4'd14, 8'd0); step();
    drive(0, 0, 0, 4'd14, 8'd0); run(2);
    drive(0, 1, 0, 4'd14, 8'd0); step();
    drive(0, 0, 0, 4'd14, 8'd0); run(3);
    check("p5_tick_count", tick_cycles.size(), 1);
    check("p5_no_done", done_cycle, -1);

    // START re-pulsed while busy with another PRESET is ignored.
    begin_scenario();
    drive(1, 0, 0, 4'd10, 8'd2); step();
    drive(0, 0, 0, 4'd10, 8'd2); run(3);
    drive(1, 0, 0, 4'd3,  8'd7); run(4);
    drive(0, 0, 0, 4'd3,  8'd7); run(12);
    check("p6_done", done_cycle - c0, 14);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      clr_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 4) == 0,
            ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 4)));
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ls161_seq_ctrl.md
Name: ls161_seq_ctrl

Overview:
Control sequencer that sits directly upstream of the team's 4-bit LS161-style synchronous counter and drives its D, LOAD_n, ENP and ENT inputs. It uses the counter as a programmable divider:
- loads a preset value,
- counts to terminal,
- reloads on each RCO,
- tallies completed periods and signals DONE after a programmed repeat count.

The counter's RCO feeds back into this block.

Parameters:
- CNT_W, 8, width of REPEAT and PERIODS (periods-completed tally).
- PRE_W, 4, width of PRESET/D; fixed at 4 to match the counter.

Ports:
- CLK      in   1      clock; all state updates on rising edge
- CLR_n    in   1      reset; synchronous, active-low
- START    in   1      start request; sampled only in IDLE
- STOP     in   1      abort; sampled in LOAD/COUNT
- HOLD     in   1      pause counting (ENP low) while in COUNT
- PRESET   in   4      reload value; period = 16 - PRESET cycles
- REPEAT   in   CNT_W  number of periods to run; 0 = run until STOP
- RCO      in   1      ripple carry from downstream counter
- D        out  4      parallel load value to counter (latched PRESET)
- LOAD_n   out  1      active-low load to counter
- ENP      out  1      count enable parallel
- ENT      out  1      count enable trickle
- BUSY     out  1      high in LOAD/COUNT
- TICK     out  1      1-cycle pulse the cycle after each terminal-count edge
- DONE     out  1      1-cycle pulse the cycle after the final period
- PERIODS  out  CNT_W  periods completed since last START

Behaviour:
Reset (CLR_n low at a CLK edge):
- state=IDLE, D=0, LOAD_n=1, ENP=0, ENT=0, BUSY=0, TICK=0, DONE=0, PERIODS=0.
- Reset overrides every other input, including mid-count.

States: IDLE, LOAD, COUNT.

IDLE:
- LOAD_n=1, ENP=ENT=0.
- START=1 at an edge:
  - latch PRESET into D and REPEAT into rep_r;
  - clear PERIODS;
  - go to LOAD.
- DONE/TICK pulses end after one cycle.

LOAD (exactly 1 cycle):
- LOAD_n=0, ENP=ENT=0; the counter loads D at the closing edge.
- Next state COUNT. If STOP=1, go to IDLE instead (counter still loads).

COUNT:
- ENT=1; ENP = ~HOLD (combinational from HOLD).
- term = RCO & ~HOLD.
- LOAD_n = ~term (combinational from RCO). The counter reloads D instead of wrapping 15->0, so the counter never shows 0 unless PRESET=0.
- On a term edge:
  - PERIODS <= PERIODS+1 (wraps modulo 2^CNT_W);
  - TICK=1 next cycle.
  - If rep_r != 0 and PERIODS+1 == rep_r: go to IDLE, DONE=1 next cycle, BUSY=0 next cycle.
- HOLD=1: counter frozen; RCO may stay high (Q=15) but no reload and no tally.

Priority and boundary rules:
- STOP=1 in COUNT: IDLE next cycle, no DONE.
  - If term coincides with STOP: reload still happens this edge, PERIODS increments and TICK pulses, DONE suppressed.
- START while BUSY: ignored. PRESET/REPEAT changes while BUSY: ignored (latched values used).
- PRESET=15: every COUNT cycle is terminal; TICK high every cycle after the first.
- REPEAT=0: runs indefinitely; PERIODS wraps silently.
- START and STOP together in IDLE: start accepted; STOP is ignored in IDLE.
- Latency: START edge -> LOAD_n low next cycle -> counter holds PRESET one cycle later.

Decomposition:
- Shared package ls161_pkg:
  - state enum (IDLE/LOAD/COUNT);
  - constant CNT_TERM=4'hF;
  - CNT_W default.
- No RTL sub-module needed; single FSM plus tally register.
- Bench instantiates the team's LS161-style counter as the downstream load, wired D/LOAD_n/ENP/ENT -> counter and counter RCO -> RCO. CLR_n is shared: counter clears asynchronously, this block synchronously.

Test Plan:
1. Reset: CLR_n low 2 edges mid-COUNT -> all outputs at reset values, state IDLE, counter Q=0.
2. PRESET=12, REPEAT=3, START pulse at cycle 0:
   - LOAD_n low cycle 1;
   - Q=12..15 in cycles 2-5;
   - terminals in cycles 5, 9, 13; TICK in cycles 6, 10, 14;
   - DONE=1 and BUSY=0 in cycle 14; PERIODS=3; Q rests at 12.
3. HOLD high for 3 cycles while Q=15 -> no reload, no TICK, PERIODS unchanged; release -> terminal on the next edge, period stretched by 3.
4. PRESET=15, REPEAT=5 -> TICK every cycle in cycles 3-7, DONE in cycle 7, PERIODS=5.
5. STOP asserted in the same cycle as a terminal (PRESET=14, REPEAT=0) -> TICK=1, PERIODS incremented, DONE=0, IDLE next cycle, ENP=ENT=0.
6. START re-pulsed while BUSY with a different PRESET -> ignored; D and period unchanged until DONE.
